// File: rtl/regfile_pkg.sv
// Shared defaults and the checkpoint-operation encoding for the negedge register file.
package regfile_pkg;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefDepth   = 32;
  localparam int unsigned DefNumCkpt = 4;

  typedef enum logic [1:0] {
    CkptNone    = 2'b00,
    CkptSave    = 2'b01,
    CkptRestore = 2'b10,
    CkptBoth    = 2'b11
  } ckpt_op_e;

  function automatic ckpt_op_e decode_ckpt_op(input logic save, input logic restore);
    return ckpt_op_e'({restore, save});
  endfunction

endpackage

// File: rtl/ckpt_lifo_ctrl.sv
// Checkpoint LIFO bookkeeping: occupancy count, full/empty/error flags and op decode.
module ckpt_lifo_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_CKPT = DefNumCkpt,
  localparam int unsigned CW = $clog2(NUM_CKPT) + 1,
  localparam int unsigned SW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ckpt_save,
  input  logic          ckpt_restore,
  output logic [CW-1:0] ckpt_count,
  output logic          ckpt_full,
  output logic          ckpt_empty,
  output logic          ckpt_err,
  output logic          do_save,
  output logic          do_restore,
  output logic          drop_writes,
  output logic [SW-1:0] save_slot,
  output logic [SW-1:0] restore_slot
);

  ckpt_op_e      op;
  logic [CW-1:0] count_q;
  logic          err_q;

  always_comb begin
    op          = decode_ckpt_op(ckpt_save, ckpt_restore);
    ckpt_count  = count_q;
    ckpt_err    = err_q;
    ckpt_full   = (count_q == CW'(NUM_CKPT));
    ckpt_empty  = (count_q == '0);
    do_save     = (op == CkptSave) && !ckpt_full;
    do_restore  = (op == CkptRestore) && !ckpt_empty;
    // A rejected restore (empty) lets the writes through; an accepted one replaces them.
    drop_writes = (op == CkptBoth) || do_restore;
    save_slot    = count_q[SW-1:0];
    restore_slot = save_slot - SW'(1);
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (op)
        CkptSave: begin
          if (ckpt_full) err_q <= 1'b1;
          else           count_q <= count_q + CW'(1);
        end
        CkptRestore: begin
          if (ckpt_empty) err_q <= 1'b1;
          else            count_q <= count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_negedge_ckpt.sv
// Two-write-port register file committing on the falling clock edge, with a LIFO of
// whole-array checkpoints.
module regfile_negedge_ckpt
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_CKPT  = DefNumCkpt,
  parameter int unsigned ZERO_REG0 = 1,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(NUM_CKPT) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   we,
  input  logic [1:0][AW-1:0]           waddr,
  input  logic [1:0][WIDTH-1:0]        wdata,
  input  logic [NUM_RD-1:0][AW-1:0]    raddr,
  output logic [NUM_RD-1:0][WIDTH-1:0] rdata,
  input  logic                         ckpt_save,
  input  logic                         ckpt_restore,
  output logic [CW-1:0]                ckpt_count,
  output logic                         ckpt_full,
  output logic                         ckpt_empty,
  output logic                         ckpt_err
);

  localparam int unsigned SW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ckpt_mem [NUM_CKPT][DEPTH];

  logic          do_save;
  logic          do_restore;
  logic          drop_writes;
  logic [SW-1:0] save_slot;
  logic [SW-1:0] restore_slot;
  logic [1:0]    wr_en;

  ckpt_lifo_ctrl #(
    .NUM_CKPT (NUM_CKPT)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_count   (ckpt_count),
    .ckpt_full    (ckpt_full),
    .ckpt_empty   (ckpt_empty),
    .ckpt_err     (ckpt_err),
    .do_save      (do_save),
    .do_restore   (do_restore),
    .drop_writes  (drop_writes),
    .save_slot    (save_slot),
    .restore_slot (restore_slot)
  );

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = we[p] && !drop_writes && !((ZERO_REG0 != 0) && (waddr[p] == '0));
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rdata[r] = mem[raddr[r]];
      if ((ZERO_REG0 != 0) && (raddr[r] == '0)) rdata[r] = '0;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
        for (int c = 0; c < NUM_CKPT; c++) ckpt_mem[SW'(c)][AW'(i)] <= '0;
      end
    end else begin
      // The snapshot reads mem before this edge's writes land, so it holds the pre-edge state.
      if (do_save) begin
        for (int i = 0; i < DEPTH; i++) ckpt_mem[save_slot][AW'(i)] <= mem[AW'(i)];
      end
      if (do_restore) begin
        for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= ckpt_mem[restore_slot][AW'(i)];
      end else begin
        // Port 1 is assigned last so it wins an address collision.
        if (wr_en[0]) mem[waddr[0]] <= wdata[0];
        if (wr_en[1]) mem[waddr[1]] <= wdata[1];
      end
    end
  end

endmodule

// File: tb/tb_regfile_negedge_ckpt.sv
// Directed vector table plus randomized traffic checked against an array/stack model.
module tb_regfile_negedge_ckpt;

  localparam int NCK = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       we;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rdata;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic [2:0]       ckpt_count;
  logic             ckpt_full;
  logic             ckpt_empty;
  logic             ckpt_err;

  int n_cmp = 0;
  int n_mis = 0;

  regfile_negedge_ckpt #(
    .WIDTH     (32),
    .DEPTH     (32),
    .NUM_RD    (2),
    .NUM_CKPT  (NCK),
    .ZERO_REG0 (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_count   (ckpt_count),
    .ckpt_full    (ckpt_full),
    .ckpt_empty   (ckpt_empty),
    .ckpt_err     (ckpt_err)
  );

  always #5 clk = ~clk;

  // Reference model: live array plus a stack of saved copies.
  logic [31:0] m_arr [32];
  logic [31:0] m_snap [NCK][32];
  int          m_cnt;
  logic        m_err;

  task automatic model_step();
    if (!reset) begin
      foreach (m_arr[i]) m_arr[i] = '0;
      m_cnt = 0;
      m_err = 1'b0;
      return;
    end
    if (ckpt_save && ckpt_restore) return;
    if (ckpt_restore) begin
      if (m_cnt == 0) begin
        m_err = 1'b1;
      end else begin
        m_cnt--;
        foreach (m_arr[i]) m_arr[i] = m_snap[m_cnt][i];
        return;
      end
    end
    if (ckpt_save) begin
      if (m_cnt == NCK) begin
        m_err = 1'b1;
      end else begin
        foreach (m_arr[i]) m_snap[m_cnt][i] = m_arr[i];
        m_cnt++;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (we[p] && waddr[p] != 5'd0) m_arr[waddr[p]] = wdata[p];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1; state commits at negedge; outputs sampled at posedge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
  endtask

  task automatic drive(input logic rst, input logic [1:0] w, input logic [4:0] a0,
                       input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1,
                       input logic sv, input logic rs, input logic [4:0] r0, input logic [4:0] r1);
    reset = rst; we = w; waddr[0] = a0; wdata[0] = d0; waddr[1] = a1; wdata[1] = d1;
    ckpt_save = sv; ckpt_restore = rs; raddr[0] = r0; raddr[1] = r1;
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  w;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        sv;
    logic        rs;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    int          ecnt;
    logic        eerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic rst, input logic [1:0] w, input logic [4:0] a0,
                     input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1,
                     input logic sv, input logic rs, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [31:0] e0, input logic [31:0] e1, input int ec, input logic ee);
    vec_t v;
    v.name = n; v.rst = rst; v.w = w; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.sv = sv; v.rs = rs; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.ecnt = ec; v.eerr = ee;
    vq.push_back(v);
  endtask

  task automatic check_flags(input string n, input int ec, input logic ee);
    chk({n, "_count"}, 32'(ckpt_count), 32'(ec));
    chk({n, "_full"},  32'(ckpt_full),  32'(ec == NCK));
    chk({n, "_empty"}, 32'(ckpt_empty), 32'(ec == 0));
    chk({n, "_err"},   32'(ckpt_err),   32'(ee));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name             rst we   a0  d0            a1 d1     sv rs r0 r1  e0            e1            cnt err
    add("reset",          0, 2'b00, 0, 0,            0, 0,     0, 0, 5, 0,  0,            0,            0, 0);
    add("wr_p0",          1, 2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0, 5, 3,  32'hDEADBEEF, 0,            0, 0);
    add("both_ports",     1, 2'b11, 3, 32'h11,       3, 32'h22, 0, 0, 3, 5, 32'h22,       32'hDEADBEEF, 0, 0);
    add("zero_reg",       1, 2'b01, 0, 32'hFF,       0, 0,     0, 0, 0, 3,  0,            32'h22,       0, 0);
    add("set_e7",         1, 2'b01, 7, 32'hA,        0, 0,     0, 0, 7, 3,  32'hA,        32'h22,       0, 0);
    add("save_wr",        1, 2'b01, 7, 32'hB,        0, 0,     1, 0, 7, 5,  32'hB,        32'hDEADBEEF, 1, 0);
    add("restore",        1, 2'b00, 0, 0,            0, 0,     0, 1, 7, 5,  32'hA,        32'hDEADBEEF, 0, 0);
    add("restore_empty",  1, 2'b10, 0, 0,            9, 32'h99, 0, 1, 9, 7, 32'h99,       32'hA,        0, 1);
    add("reset_override", 0, 2'b01, 5, 32'h1234,     0, 0,     1, 0, 5, 9,  0,            0,            0, 0);
    add("save_wr2",       1, 2'b01, 2, 32'h77,       0, 0,     1, 0, 2, 0,  32'h77,       0,            1, 0);
    add("save_restore",   1, 2'b01, 2, 32'h5,        0, 0,     1, 1, 2, 0,  32'h77,       0,            1, 0);
    add("save2",          1, 2'b00, 0, 0,            0, 0,     1, 0, 4, 2,  0,            32'h77,       2, 0);
    add("save3_wr",       1, 2'b01, 4, 32'h44,       0, 0,     1, 0, 4, 2,  32'h44,       32'h77,       3, 0);
    add("save4",          1, 2'b00, 0, 0,            0, 0,     1, 0, 4, 2,  32'h44,       32'h77,       4, 0);
    add("save_full_wr",   1, 2'b01, 4, 32'h55,       0, 0,     1, 0, 4, 2,  32'h55,       32'h77,       4, 1);
    add("restore_s3",     1, 2'b00, 0, 0,            0, 0,     0, 1, 4, 2,  32'h44,       32'h77,       3, 1);
    add("restore_s2_wr",  1, 2'b01, 2, 32'h123,      0, 0,     0, 1, 4, 2,  0,            32'h77,       2, 1);
    add("reset_mid",      0, 2'b00, 0, 0,            0, 0,     0, 0, 4, 2,  0,            0,            0, 0);

    drive(1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].w, vq[k].a0, vq[k].d0, vq[k].a1, vq[k].d1,
            vq[k].sv, vq[k].rs, vq[k].r0, vq[k].r1);
      cycle();
      chk({vq[k].name, "_rd0"}, rdata[0], vq[k].e0);
      chk({vq[k].name, "_rd1"}, rdata[1], vq[k].e1);
      check_flags(vq[k].name, vq[k].ecnt, vq[k].eerr);
      #1;
    end

    // Random traffic; low addresses are favoured so port collisions happen often.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] a0, a1;
      a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 63) != 0, 2'($urandom), a0, $urandom, a1, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0) ? a1 : a0);
      cycle();
      chk("rand_rd0", rdata[0], m_arr[raddr[0]]);
      chk("rand_rd1", rdata[1], m_arr[raddr[1]]);
      check_flags("rand", m_cnt, m_err);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_negedge_ckpt.md
REGFILE_NEGEDGE_CKPT -- requirements
Module: regfile_negedge_ckpt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bits per entry.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries; power of 2, >=2.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_CKPT, default 4, number of checkpoint slots; >=1.
REQ-005 SHALL have parameter ZERO_REG0, default 1; when 1, entry 0 reads 0 and is never written.
REQ-006 SHALL have clk, input, 1 bit, clock; all state updates on its falling edge.
REQ-007 SHALL have reset, input, 1 bit; reset is synchronous and active-low.
REQ-008 SHALL have we, input, [1:0], per-write-port enable.
REQ-009 SHALL have waddr, input, 2 x log2(DEPTH), per-port write address.
REQ-010 SHALL have wdata, input, 2 x WIDTH, per-port write data.
REQ-011 SHALL have raddr, input, NUM_RD x log2(DEPTH), read addresses.
REQ-012 SHALL have rdata, output, NUM_RD x WIDTH, read data.
REQ-013 SHALL have ckpt_save, input, 1 bit; pushes a snapshot of all entries.
REQ-014 SHALL have ckpt_restore, input, 1 bit; pops the newest snapshot into the live array.
REQ-015 SHALL have ckpt_count, output, log2(NUM_CKPT)+1 bits; occupied slots.
REQ-016 SHALL have ckpt_full and ckpt_empty, outputs, 1 bit each.
REQ-017 SHALL have ckpt_err, output, 1 bit; sticky overflow/underflow flag.

Function
REQ-018 Writes SHALL commit on negedge clk, so a posedge-sampled read in the same cycle sees the new value.
REQ-019 rdata SHALL be combinational from raddr and live array; no bypass from wdata.
REQ-020 Both write ports to one address on one edge: port 1 SHALL win.
REQ-021 ZERO_REG0=1: writes to address 0 SHALL be dropped; rdata for address 0 SHALL be 0.
REQ-022 Checkpoints SHALL form a LIFO; save copies the pre-edge live array (excluding same-edge writes) into slot ckpt_count, then increments count.
REQ-023 Restore SHALL copy slot ckpt_count-1 into the live array and decrement count; same-edge writes SHALL be discarded.
REQ-024 Save and restore on one edge SHALL be a no-op on slots and count; live array SHALL be left unchanged; writes that edge SHALL be discarded.
REQ-025 Save when full SHALL be ignored and set ckpt_err; restore when empty SHALL be ignored, same-edge writes SHALL commit normally, and ckpt_err SHALL be set.
REQ-026 ckpt_full SHALL equal (ckpt_count==NUM_CKPT); ckpt_empty SHALL equal (ckpt_count==0).
REQ-027 ckpt_err SHALL clear only on reset.

Reset
REQ-028 reset==0 at negedge clk SHALL clear all entries and all slots to 0, ckpt_count and ckpt_err to 0; reset overrides all other inputs that edge.
REQ-029 Reset mid-sequence SHALL discard all saved snapshots; after reset ckpt_empty=1, ckpt_full=0.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the defaults for WIDTH, DEPTH and NUM_CKPT and the ckpt-op enum (NONE, SAVE, RESTORE, BOTH).
REQ-031 One sub-module, ckpt_lifo_ctrl, SHALL own ckpt_count, the full/empty/err flags and the op decode; the array storage stays in the top.

Verification
REQ-032 Write 0xDEADBEEF to entry 5 via port 0, read the same cycle on posedge -> rdata=0xDEADBEEF.
REQ-033 Both ports write entry 3 (0x11, 0x22) -> entry 3=0x22; write 0xFF to entry 0 with ZERO_REG0=1 -> reads 0.
REQ-034 Save with entry 7=0xA, write 0xB, restore -> entry 7=0xA, ckpt_count 1->0, ckpt_empty=1.
REQ-035 NUM_CKPT=4: five saves -> count=4, full=1, err=1; restore on empty after reset -> err=1, count=0.
REQ-036 Save+restore on the same edge with write 0x5 to entry 2 -> entry 2 unchanged, count unchanged.
REQ-037 Two saves, then reset low for one negedge -> all entries 0, count=0, err=0, empty=1.
